id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised RISC-V decode stage: register file, control decode, immediate generation and the ID/EX pipeline register in one block. It adds three things over the plain decode stage: WB-to-ID write bypass, load-use hazard detection with bubble insertion, and flush/hold handling. It sits between the IF/ID register and EX. The SDU debug read port is retained.

## Interface
- XLEN, 32: datapath width; immediates are sign-extended to XLEN.
- NREG, 32: number of architectural registers (power of two, 2..32). AW = clog2(NREG); register-address fields use ir bits [AW-1:0] of each 5-bit field.
- BYPASS, 1: 1 means a WB write to the register being read in the same cycle is forwarded to the read data.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_pc  in  XLEN  PC of if_ir.
- if_ir  in  32  instruction.
- wb_we  in  1  WB register write enable.
- wb_wa  in  AW  WB write address.
- wb_wd  in  XLEN  WB write data.
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- ex_hold  in  1  EX cannot accept; freeze ID/EX.
- ra_sdu  in  AW  debug read address.
- rd_sdu  out  XLEN  debug read data (combinational, no bypass).
- id_stall  out  1  IF/ID must hold its contents this cycle.
- ex_valid, ex_pc, ex_reg_a, ex_reg_b, ex_imm  out  1/XLEN/XLEN/XLEN/XLEN  registered ID/EX outputs.
- ex_ctl  out  12  registered control word.
- ex_rd, ex_rs1, ex_rs2  out  AW  registered register addresses (for EX forwarding).

## Operation
- Register file: NREG×XLEN; x0 reads 0, writes to it are ignored. Write at posedge when wb_we. Reset clears all entries.
- Read: rs1 = if_ir[19:15], rs2 = if_ir[24:20]. If BYPASS and wb_we and wb_wa == rs and rs != 0, the read returns wb_wd; otherwise it returns the array value.
- ctl bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] branch, [5] jal, [6] jalr, [7] alu_src_imm, [9:8] alu_op (00 add, 01 branch compare, 10 R-type, 11 I-ALU), [10] auipc, [11] lui.
- Decode by opcode:
  - R 0110011 → reg_write, alu_op=10.
  - I-ALU 0010011 → reg_write, alu_src, alu_op=11.
  - load 0000011 → reg_write, mem_read, mem_to_reg, alu_src.
  - store 0100011 → mem_write, alu_src.
  - branch 1100011 → branch, alu_op=01.
  - jal 1101111 → reg_write, jal.
  - jalr 1100111 → reg_write, jalr, alu_src.
  - lui 0110111 → reg_write, lui, alu_src.
  - auipc 0010111 → reg_write, auipc, alu_src.
  - Any other opcode → ctl = 0, which is a NOP.
- Immediate formats, each sign-extended from ir[31]:
  - I: load, I-ALU, jalr.
  - S: store.
  - B: branch.
  - U: ir[31:12]<<12.
  - J: jal.
  - All others: 0.
- Source usage:
  - uses_rs1 for all formats except U, J and unknown.
  - uses_rs2 for R, S and B only.
- Load-use hazard: if_valid & ex_valid & ex_ctl[1] & ex_rd != 0 & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)).
- ID/EX update priority, evaluated each posedge:
  1. flush: ex_valid←0, ex_ctl←0; id_stall=0.
  2. ex_hold: all ID/EX registers keep their value; id_stall=1.
  3. hazard: bubble, i.e. ex_valid←0, ex_ctl←0; id_stall=1.
  4. Otherwise: load the decoded values; ex_valid←if_valid; ex_ctl←decoded ctl if if_valid, else 0; id_stall=0.
- Address registers:
  - ex_rd←ir[11:7] only when ctl[0]=1, else 0.
  - ex_rs1, ex_rs2 ← 0 when the field is unused.

## Timing
- Reset: every ex_* output is 0, register file is 0, id_stall=0 (combinational from the reset state).
- Decode-to-EX latency is 1 cycle.
- id_stall is combinational from if_ir, the ID/EX state, flush and ex_hold.
- A WB write in cycle N is visible to an ID read in cycle N via bypass, or in N+1 from the array.
- A load-use stall lasts exactly 1 cycle. The next cycle sees ex_valid=0, so the hazard clears.
- Simultaneous flush and ex_hold: flush wins.
- Simultaneous flush and hazard: no stall is raised.
- rst asserted mid-stall clears everything immediately. The stall does not persist after release.

## Test plan
- Reset, then R-type add x3,x1,x2 with x1=5, x2=7 → next cycle ex_valid=1, ex_reg_a=5, ex_reg_b=7, ex_ctl=0x201, ex_rd=3.
- WB writes x1=0xDEADBEEF in the same cycle that ID decodes addi x4,x1,-1 → ex_reg_a=0xDEADBEEF, ex_imm=0xFFFFFFFF, ex_ctl=0x381. With BYPASS=0, ex_reg_a holds the old value.
- lw x5,0(x1) followed by add x6,x5,x2 → id_stall=1 for 1 cycle; the bubble gives ex_valid=0, ex_ctl=0; the add then issues. The same sequence with rd=x0 gives no stall.
- beq offset -8 (ir=0xFE208CE3) → ex_imm=0xFFFFFFF8, ex_ctl=0x110. lui x7,0x12345 → ex_imm=0x12345000.
- flush and ex_hold both high with a valid instruction → ex_valid=0, id_stall=0. ex_hold alone for 3 cycles → ID/EX outputs unchanged, id_stall=1.
- Write x31 with NREG=16 → the address aliases to x15. Writes to x0 always read back as 0. The SDU reads every register correctly after reset (all 0).

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- RISC-V decode stage with ID/EX pipeline register.
//
// Contains the register file (with optional WB->ID write bypass), control
// decode, immediate generation, load-use hazard detection with bubble
// insertion, flush/hold handling and a combinational debug read port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_valid, if_pc, if_ir    instruction presented by the IF/ID register
//   wb_we, wb_wa, wb_wd       register-file write from WB
//   flush                     kill the instruction currently in ID
//   ex_hold                   EX cannot accept; freeze ID/EX
//   ra_sdu, rd_sdu            debug read port (array value, no bypass)
//   id_stall                  IF/ID must hold its contents this cycle
//   ex_*                      registered ID/EX outputs
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_ir,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  input  logic            ex_hold,
  input  logic [AW-1:0]   ra_sdu,
  output logic [XLEN-1:0] rd_sdu,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_reg_a,
  output logic [XLEN-1:0] ex_reg_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [11:0]     ex_ctl,
  output logic [AW-1:0]   ex_rd,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] rf [NREG];

  logic [AW-1:0]   rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [11:0]     ctl, ctl_v;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] rdata_a, rdata_b;
  logic            hazard;

  assign rs1    = if_ir[15 +: AW];
  assign rs2    = if_ir[20 +: AW];
  assign rd     = if_ir[7 +: AW];
  assign opcode = if_ir[6:0];

  // Control word, immediate and source usage
  always_comb begin
    ctl      = '0;
    imm32    = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP_R: begin
        ctl      = 12'h201;  // reg_write, alu_op=10
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IALU: begin
        ctl      = 12'h381;  // reg_write, alu_src, alu_op=11
        imm32    = {{20{if_ir[31]}}, if_ir[31:20]};
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctl      = 12'h08B;  // reg_write, mem_read, mem_to_reg, alu_src
        imm32    = {{20{if_ir[31]}}, if_ir[31:20]};
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctl      = 12'h084;  // mem_write, alu_src
        imm32    = {{20{if_ir[31]}}, if_ir[31:25], if_ir[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctl      = 12'h110;  // branch, alu_op=01
        imm32    = {{19{if_ir[31]}}, if_ir[31], if_ir[7], if_ir[30:25],
                    if_ir[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctl      = 12'h021;  // reg_write, jal
        imm32    = {{11{if_ir[31]}}, if_ir[31], if_ir[19:12], if_ir[20],
                    if_ir[30:21], 1'b0};
      end
      OP_JALR: begin
        ctl      = 12'h0C1;  // reg_write, jalr, alu_src
        imm32    = {{20{if_ir[31]}}, if_ir[31:20]};
        uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctl      = 12'h881;  // reg_write, lui, alu_src
        imm32    = {if_ir[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctl      = 12'h481;  // reg_write, auipc, alu_src
        imm32    = {if_ir[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  assign imm   = XLEN'($signed(imm32));
  assign ctl_v = if_valid ? ctl : '0;

  // Register read with optional same-cycle WB forwarding
  assign rdata_a = ((BYPASS != 0) && wb_we && (wb_wa == rs1) && (rs1 != '0))
                   ? wb_wd : rf[rs1];
  assign rdata_b = ((BYPASS != 0) && wb_we && (wb_wa == rs2) && (rs2 != '0))
                   ? wb_wd : rf[rs2];
  assign rd_sdu  = rf[ra_sdu];

  assign hazard = if_valid && ex_valid && ex_ctl[1] && (ex_rd != '0) &&
                  ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

  // flush has priority, so neither hold nor a hazard can stall IF while killing
  assign id_stall = !flush && (ex_hold || hazard);

  // Register file; x0 is never written so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && (wb_wa != '0)) begin
      rf[wb_wa] <= wb_wd;
    end
  end

  // ID/EX register: flush > hold > hazard bubble > normal load.
  // Flush and bubble only clear valid/ctl; the data fields are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_reg_a <= '0;
      ex_reg_b <= '0;
      ex_imm   <= '0;
      ex_ctl   <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctl   <= '0;
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ex_ctl   <= '0;
    end else begin
      ex_valid <= if_valid;
      ex_pc    <= if_pc;
      ex_reg_a <= rdata_a;
      ex_reg_b <= rdata_b;
      ex_imm   <= imm;
      ex_ctl   <= ctl_v;
      ex_rd    <= ctl_v[0] ? rd : '0;
      ex_rs1   <= uses_rs1 ? rs1 : '0;
      ex_rs2   <= uses_rs2 ? rs2 : '0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe. The driver issues one input vector per
// cycle and queues the outputs expected during that cycle; the monitor pops
// and compares on each falling edge. Two extra instances (BYPASS=0, NREG=16)
// share the stimulus and have selected outputs checked.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc, if_ir;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush, ex_hold;
  logic [4:0]  ra_sdu;

  logic [31:0] rd_sdu, ex_pc, ex_reg_a, ex_reg_b, ex_imm;
  logic        id_stall, ex_valid;
  logic [11:0] ex_ctl;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;

  logic [31:0] nb_rd_sdu, nb_pc, nb_reg_a, nb_reg_b, nb_imm;
  logic        nb_stall, nb_valid;
  logic [11:0] nb_ctl;
  logic [4:0]  nb_rd, nb_rs1, nb_rs2;

  logic [31:0] s_rd_sdu, s_pc, s_reg_a, s_reg_b, s_imm;
  logic        s_stall, s_valid;
  logic [11:0] s_ctl;
  logic [3:0]  s_rd, s_rs1, s_rs2;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush),
    .ex_hold(ex_hold), .ra_sdu(ra_sdu), .rd_sdu(rd_sdu), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_reg_a(ex_reg_a),
    .ex_reg_b(ex_reg_b), .ex_imm(ex_imm), .ex_ctl(ex_ctl), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2));

  id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush),
    .ex_hold(ex_hold), .ra_sdu(ra_sdu), .rd_sdu(nb_rd_sdu), .id_stall(nb_stall),
    .ex_valid(nb_valid), .ex_pc(nb_pc), .ex_reg_a(nb_reg_a),
    .ex_reg_b(nb_reg_b), .ex_imm(nb_imm), .ex_ctl(nb_ctl), .ex_rd(nb_rd),
    .ex_rs1(nb_rs1), .ex_rs2(nb_rs2));

  id_stage_pipe #(.XLEN(32), .NREG(16), .BYPASS(1)) dut_16 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
    .wb_we(wb_we), .wb_wa(wb_wa[3:0]), .wb_wd(wb_wd), .flush(flush),
    .ex_hold(ex_hold), .ra_sdu(ra_sdu[3:0]), .rd_sdu(s_rd_sdu),
    .id_stall(s_stall), .ex_valid(s_valid), .ex_pc(s_pc), .ex_reg_a(s_reg_a),
    .ex_reg_b(s_reg_b), .ex_imm(s_imm), .ex_ctl(s_ctl), .ex_rd(s_rd),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2));

  typedef struct {
    logic        v;
    logic [31:0] pc, a, b, imm;
    logic [11:0] ctl;
    logic [4:0]  rd, rs1, rs2;
    logic        stall;
    logic [31:0] sdu, sdu16, nb_a, a16;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t m;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Monitor: one queued expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.v});
      chk("ex_pc",    ex_pc,    m.pc);
      chk("ex_reg_a", ex_reg_a, m.a);
      chk("ex_reg_b", ex_reg_b, m.b);
      chk("ex_imm",   ex_imm,   m.imm);
      chk("ex_ctl",   {20'b0, ex_ctl}, {20'b0, m.ctl});
      chk("ex_rd",    {27'b0, ex_rd},  {27'b0, m.rd});
      chk("ex_rs1",   {27'b0, ex_rs1}, {27'b0, m.rs1});
      chk("ex_rs2",   {27'b0, ex_rs2}, {27'b0, m.rs2});
      chk("id_stall", {31'b0, id_stall}, {31'b0, m.stall});
      chk("rd_sdu",   rd_sdu,   m.sdu);
      chk("nobyp_reg_a", nb_reg_a, m.nb_a);
      chk("nreg16_reg_a", s_reg_a, m.a16);
      chk("nreg16_rd_sdu", s_rd_sdu, m.sdu16);
    end
  end

  // Start a cycle: inputs return to idle, per-cycle expectations default
  task automatic next();
    @(posedge clk);
    #1;
    rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_ir = '0;
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0; flush = 1'b0; ex_hold = 1'b0;
    ra_sdu = '0;
    e.stall = 1'b0; e.sdu = '0; e.sdu16 = '0;
  endtask

  task automatic inst(input logic v, input logic [31:0] pc, input logic [31:0] ir);
    if_valid = v; if_pc = pc; if_ir = ir;
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    wb_we = 1'b1; wb_wa = wa; wb_wd = wd;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, a, b, imm,
                    input logic [11:0] ctl, input logic [4:0] rd, rs1, rs2);
    e.v = v; e.pc = pc; e.a = a; e.b = b; e.imm = imm; e.ctl = ctl;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.nb_a = a; e.a16 = a;
  endtask

  task automatic push();
    q.push_back(e);
  endtask

  localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
  localparam logic [31:0] ADDI_4_1_M = 32'hFFF08213;
  localparam logic [31:0] LW_5_1     = 32'h0000A283;
  localparam logic [31:0] ADD_6_5_2  = 32'h00228333;
  localparam logic [31:0] LW_0_1     = 32'h0000A003;
  localparam logic [31:0] ADD_6_0_2  = 32'h00200333;
  localparam logic [31:0] BEQ_M8     = 32'hFE208CE3;
  localparam logic [31:0] LUI_7      = 32'h123453B7;
  localparam logic [31:0] ADDI_9_31  = 32'h000F8493;
  localparam logic [31:0] DB         = 32'hDEADBEEF;

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_ir = '0; wb_we = 1'b0;
    wb_wa = '0; wb_wd = '0; flush = 1'b0; ex_hold = 1'b0; ra_sdu = '0;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.stall = 1'b0; e.sdu = '0; e.sdu16 = '0;
    repeat (2) @(posedge clk);

    // Reset state, debug port sweep over every register
    for (int i = 0; i < 32; i++) begin
      next(); ra_sdu = 5'(i); push();
    end

    next(); wb(1, 32'd5); push();
    next(); wb(2, 32'd7); push();
    next(); wb(0, 32'h55); ra_sdu = 1; e.sdu = 5; e.sdu16 = 5; push();
    // add x3,x1,x2 ; x0 write must have been dropped
    next(); inst(1, 32'h100, ADD_3_1_2); push();
    // addi x4,x1,-1 decoded while WB writes x1
    next(); inst(1, 32'h104, ADDI_4_1_M); wb(1, DB); ra_sdu = 2; e.sdu = 7; e.sdu16 = 7;
    ex(1, 32'h100, 5, 7, 0, 12'h201, 3, 1, 2); push();
    // lw x5,0(x1)
    next(); inst(1, 32'h108, LW_5_1);
    ex(1, 32'h104, DB, 0, 32'hFFFFFFFF, 12'h381, 4, 1, 0); e.nb_a = 5; push();
    // add x6,x5,x2 -> load-use stall
    next(); inst(1, 32'h10C, ADD_6_5_2);
    ex(1, 32'h108, DB, 0, 0, 12'h08B, 5, 1, 0); e.stall = 1; push();
    next(); inst(1, 32'h10C, ADD_6_5_2);
    ex(0, 32'h108, DB, 0, 0, 12'h000, 5, 1, 0); push();
    // lw x0,0(x1) then dependent-looking add: no stall
    next(); inst(1, 32'h110, LW_0_1);
    ex(1, 32'h10C, 0, 7, 0, 12'h201, 6, 5, 2); push();
    next(); inst(1, 32'h114, ADD_6_0_2);
    ex(1, 32'h110, DB, 0, 0, 12'h08B, 0, 1, 0); push();
    next(); inst(1, 32'h118, BEQ_M8);
    ex(1, 32'h114, 0, 7, 0, 12'h201, 6, 0, 2); push();
    next(); inst(1, 32'h11C, LUI_7);
    ex(1, 32'h118, DB, 7, 32'hFFFFFFF8, 12'h110, 0, 1, 2); push();
    // flush and hold together: flush wins, no stall
    next(); inst(1, 32'h120, ADD_3_1_2); flush = 1; ex_hold = 1;
    ex(1, 32'h11C, 0, 0, 32'h12345000, 12'h881, 7, 0, 0); push();
    // hold alone for 3 cycles
    for (int i = 0; i < 3; i++) begin
      next(); inst(1, 32'h124, ADD_3_1_2); ex_hold = 1;
      ex(0, 32'h11C, 0, 0, 32'h12345000, 12'h000, 7, 0, 0); e.stall = 1; push();
    end
    next(); inst(1, 32'h124, ADD_3_1_2);
    ex(0, 32'h11C, 0, 0, 32'h12345000, 12'h000, 7, 0, 0); push();
    // flush coinciding with a load-use hazard: no stall
    next(); inst(1, 32'h128, LW_5_1);
    ex(1, 32'h124, DB, 7, 0, 12'h201, 3, 1, 2); push();
    next(); inst(1, 32'h12C, ADD_6_5_2); flush = 1;
    ex(1, 32'h128, DB, 0, 0, 12'h08B, 5, 1, 0); push();
    // x31 write; the NREG=16 instance aliases it to x15
    next(); wb(31, 32'hA5A5A5A5);
    ex(0, 32'h128, DB, 0, 0, 12'h000, 5, 1, 0); push();
    next(); inst(1, 32'h130, ADDI_9_31); ra_sdu = 31;
    e.sdu = 32'hA5A5A5A5; e.sdu16 = 32'hA5A5A5A5;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0); push();
    next(); ex(1, 32'h130, 32'hA5A5A5A5, 0, 0, 12'h381, 9, 31, 0); push();
    // reset in the middle of a load-use stall
    next(); inst(1, 32'h134, LW_5_1); ex(0, 0, 0, 0, 0, 0, 0, 0, 0); push();
    next(); inst(1, 32'h138, ADD_6_5_2);
    ex(1, 32'h134, DB, 0, 0, 12'h08B, 5, 1, 0); e.stall = 1; push();
    next(); rst = 1; inst(1, 32'h138, ADD_6_5_2); ex(0, 0, 0, 0, 0, 0, 0, 0, 0); push();
    next(); inst(1, 32'h138, ADD_6_5_2); push();
    next(); ex(1, 32'h138, 0, 0, 0, 12'h201, 6, 5, 2); push();
    next(); ex(0, 0, 0, 0, 0, 0, 0, 0, 0); push();

    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
